// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

  localparam int MUL_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mul_pp_adder.sv
// Combinational WIDTH-bit ripple-carry adder built from per-bit full-adder cells.
module mul_pp_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]         = x[i] ^ y[i] ^ w_carry[i];
    assign w_carry[i + 1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with valid/ready on both sides.
// Define ZERO_BYPASS_EN to skip the RUN phase when either operand is zero.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_m;
  logic [PW-1:0]    r_p;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_zero_op;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));
  assign w_addend = r_p[0] ? r_m : '0;

`ifdef ZERO_BYPASS_EN
  assign w_zero_op = (a == '0) || (b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  mul_pp_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (r_p[PW-1:WIDTH]),
    .y    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_zero_op ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: carry-out of the adder shifts into the top bit of P
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m     <= '0;
      r_p     <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m     <= a;
            r_p     <= w_zero_op ? '0 : {{WIDTH{1'b0}}, b};
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_p     <= {w_cout, w_sum, r_p[WIDTH-1:1]};
          r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus a full operand sweep.
module tb_shift_add_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  // Handshake counters sampled with pre-edge values
  always @(posedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) n_out++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // Expected latency from accept to first out_valid
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef ZERO_BYPASS_EN
    if (x == '0 || y == '0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called in the cycle right after the handshake edge
  task automatic wait_valid(input int lat, input logic [PW-1:0] pexp, input string tag);
    int k = 1;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_prod"}, 32'(product), 32'(pexp));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall,
                    input string tag);
    logic [PW-1:0] pexp;
    int k = 0;
    pexp = x * y;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_valid(exp_lat(x, y), pexp, tag);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_v"}, 32'(out_valid), 32'(1));
      check({tag, "_hold_p"}, 32'(product), 32'(pexp));
      check({tag, "_hold_r"}, 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_v"}, 32'(out_valid), 32'(0));
    check({tag, "_rel_r"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int acc0;
    int out0;
    logic seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_product", 32'(product), 32'(0));
    reset = 1'b0;
    tick();

    // Basic ops, including carry-out into the top bit
    op(4'd13, 4'd11, 0, "t1");
    op(4'd15, 4'd15, 1, "t2");

    // Backpressure with a pending operand that must wait for IDLE
    acc0 = n_acc;
    in_valid = 1'b1;
    a = 4'd6;
    b = 4'd7;
    tick();
    a = 4'd1;
    b = 4'd1;
    wait_valid(W + 1, 8'h2A, "t3");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_p", 32'(product), 32'(8'h2A));
      check("t3_hold_r", 32'(in_ready), 32'(0));
      check("t3_hold_v", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_idle_r", 32'(in_ready), 32'(1));
    check("t3_idle_v", 32'(out_valid), 32'(0));
    check("t3_acc_cnt", 32'(n_acc), 32'(acc0 + 1));
    tick();
    in_valid = 1'b0;
    wait_valid(W + 1, 8'h01, "t3b");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle discards the op
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rst_r", 32'(in_ready), 32'(1));
    check("t4_rst_v", 32'(out_valid), 32'(0));
    check("t4_rst_p", 32'(product), 32'(0));
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("t4_no_partial", 32'(seen), 32'(0));
    op(4'd3, 4'd5, 0, "t4b");

    // Reset wins over a simultaneous handshake
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd5;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("prio_no_op", 32'(seen), 32'(0));
    check("prio_rdy", 32'(in_ready), 32'(1));

    // Zero operand
    op(4'd0, 4'd9, 0, "t5");
    op(4'd7, 4'd0, 2, "t5b");

    // Full sweep with random stalls
    acc0 = n_acc;
    out0 = n_out;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        op(W'(ia), W'(ib), int'($urandom_range(0, 3)), $sformatf("sw_%0d_%0d", ia, ib));
      end
    end
    check("sweep_acc", 32'(n_acc - acc0), 32'(256));
    check("sweep_out", 32'(n_out - out0), 32'(n_acc - acc0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
